// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Holds the FSM state encoding, the reset_cause bit positions and a sizing helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        POR    = 2'd0,
        CPU    = 2'd1,
        RUN    = 2'd2,
        SYSRST = 2'd3
    } state_t;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_PLL = 1;
    localparam int CAUSE_SYS = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop level synchroniser for a single asynchronous input into the hclk domain.
// Flops clear on RESET so the synchronised level reads 0 until STAGES clean edges have passed.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic hclk,
    input  logic RESET,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge hclk) begin
        if (RESET) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset release for the SoC: poreset_n after a stable PLL lock, cpureset_n later.
// Also turns SYSRESETREQ into a CPU-only reset and records why resets happened.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int POR_HOLD    = 245,
    parameter int CPU_DELAY   = 10,
    parameter int SYS_HOLD    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       hclk,
    input  logic       RESET,
    input  logic       pll_locked,
    input  logic       sysresetreq,
    input  logic       cause_clr,
    output logic       poreset_n,
    output logic       cpureset_n,
    output logic [2:0] reset_cause,
    output logic       rst_busy
);

    localparam int CNT_W = $clog2(max3(POR_HOLD, CPU_DELAY, SYS_HOLD) + 1);
    localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(POR_HOLD - 1);
    localparam logic [CNT_W-1:0] CPU_LOAD = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] SYS_LOAD = CNT_W'(SYS_HOLD - 1);

    logic             w_locked_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_cnt_zero;
    logic [2:0]       r_cause;
    logic [2:0]       w_cause_set;
    logic [2:0]       w_cause_next;
    logic             r_poreset_n;
    logic             r_cpureset_n;
    logic             r_busy;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .hclk  (hclk),
        .RESET (RESET),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = w_cnt_zero ? '0 : (r_cnt - 1'b1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_dec;
        w_cause_set  = '0;
        case (r_state)
            POR: begin
                if (!w_locked_s) begin
                    w_cnt_next = POR_LOAD;
                end else if (w_cnt_zero) begin
                    w_state_next = CPU;
                    w_cnt_next   = CPU_LOAD;
                end
            end
            CPU: begin
                if (!w_locked_s) begin
                    w_state_next           = POR;
                    w_cnt_next             = POR_LOAD;
                    w_cause_set[CAUSE_PLL] = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // Lock loss takes priority over a simultaneous system reset request.
                if (!w_locked_s) begin
                    w_state_next           = POR;
                    w_cnt_next             = POR_LOAD;
                    w_cause_set[CAUSE_PLL] = 1'b1;
                end else if (sysresetreq) begin
                    w_state_next           = SYSRST;
                    w_cnt_next             = SYS_LOAD;
                    w_cause_set[CAUSE_SYS] = 1'b1;
                end
            end
            SYSRST: begin
                // A still-asserted request holds us here, so the core cannot loop through resets.
                if (!w_locked_s) begin
                    w_state_next           = POR;
                    w_cnt_next             = POR_LOAD;
                    w_cause_set[CAUSE_PLL] = 1'b1;
                end else if (w_cnt_zero && !sysresetreq) begin
                    w_state_next = CPU;
                    w_cnt_next   = CPU_LOAD;
                end
            end
            default: begin
                w_state_next = POR;
                w_cnt_next   = POR_LOAD;
            end
        endcase
        w_cause_next = (cause_clr ? 3'b000 : r_cause) | w_cause_set;
    end

    always_ff @(posedge hclk) begin
        if (RESET) begin
            r_state      <= POR;
            r_cnt        <= POR_LOAD;
            r_cause      <= 3'b001;
            r_poreset_n  <= 1'b0;
            r_cpureset_n <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_cause      <= w_cause_next;
            r_poreset_n  <= (w_state_next != POR);
            r_cpureset_n <= (w_state_next == RUN);
            r_busy       <= (w_state_next != RUN);
        end
    end

    assign poreset_n   = r_poreset_n;
    assign cpureset_n  = r_cpureset_n;
    assign reset_cause = r_cause;
    assign rst_busy    = r_busy;

endmodule
